// File: rtl/gcd_sequencer.sv
// Runs up to four stored operand pairs through an external GCD core.
// Ports: operand write (wr_*), run control (count/start/busy/done),
// result read (rd_*), core handshake (core_*).
module gcd_sequencer #(
  parameter int DEPTH = 4,
  parameter int TMO   = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic [2:0] count,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic [1:0] rd_addr,
  output logic [3:0] rd_gcd,
  output logic       rd_err,
  output logic [3:0] core_x,
  output logic [3:0] core_y,
  output logic       core_rst,
  input  logic       core_valid,
  input  logic [3:0] core_gcd
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, STORE, DONE
  } state_t;

  localparam logic [5:0] TMO_V = 6'(TMO);

  state_t state, state_nx;

  logic [3:0] op_x  [DEPTH];
  logic [3:0] op_y  [DEPTH];
  logic [3:0] res_g [DEPTH];
  logic       res_e [DEPTH];

  logic [1:0] idx;
  logic [1:0] idx_inc;
  logic [5:0] timer;
  logic [2:0] cnt;
  logic [2:0] cnt_in;
  logic [3:0] cx, cy;
  logic [3:0] hold_g;
  logic       hold_e;
  logic       got, tmo, last;

  assign idx_inc = idx + 2'd1;
  assign cnt_in  = (count > 3'd4) ? 3'd4 : count;
  // First WAIT cycle has timer==0; a valid there is left over
  // from the previous pair and must not be taken.
  assign got  = core_valid && (timer != 6'd0);
  assign tmo  = (timer == TMO_V);
  assign last = ({1'b0, idx} == (cnt - 3'd1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start)
          state_nx = (count == 3'd0) ? DONE : LAUNCH;
      LAUNCH: state_nx = WAIT;
      WAIT:
        if (got || tmo)
          state_nx = STORE;
      STORE: state_nx = last ? DONE : LAUNCH;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx    <= 2'd0;
      timer  <= 6'd0;
      cnt    <= 3'd0;
      cx     <= 4'd0;
      cy     <= 4'd0;
      hold_g <= 4'd0;
      hold_e <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        op_x[i]  <= 4'd0;
        op_y[i]  <= 4'd0;
        res_g[i] <= 4'd0;
        res_e[i] <= 1'b0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_en) begin
            op_x[wr_addr] <= wr_x;
            op_y[wr_addr] <= wr_y;
          end
          if (start && count != 3'd0) begin
            cnt <= cnt_in;
            idx <= 2'd0;
            cx  <= op_x[0];
            cy  <= op_y[0];
          end
        end
        LAUNCH: timer <= 6'd0;
        WAIT: begin
          timer <= timer + 6'd1;
          // valid beats timeout when both land together
          if (got) begin
            hold_g <= core_gcd;
            hold_e <= 1'b0;
          end else if (tmo) begin
            hold_g <= 4'd0;
            hold_e <= 1'b1;
          end
        end
        STORE: begin
          res_g[idx] <= hold_g;
          res_e[idx] <= hold_e;
          if (!last) begin
            idx <= idx_inc;
            cx  <= op_x[idx_inc];
            cy  <= op_y[idx_inc];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = !reset && (state == LAUNCH ||
                state == WAIT || state == STORE);
  assign done     = !reset && (state == DONE);
  assign core_rst = reset || (state == LAUNCH);
  assign core_x   = reset ? 4'd0 : cx;
  assign core_y   = reset ? 4'd0 : cy;
  assign rd_gcd   = res_g[rd_addr];
  assign rd_err   = res_e[rd_addr];

endmodule

// File: tb/tb_gcd_sequencer.sv
// Directed bench for gcd_sequencer with a subtractive GCD core model.
// Core source selectable: model, stuck-invalid stub, or manual drive.
module tb_gcd_sequencer;

  logic       clk = 0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_x, wr_y;
  logic [2:0] count;
  logic       start;
  logic       busy, done;
  logic [1:0] rd_addr;
  logic [3:0] rd_gcd;
  logic       rd_err;
  logic [3:0] core_x, core_y;
  logic       core_rst;
  logic       core_valid;
  logic [3:0] core_gcd;

  int errors = 0;
  int checks = 0;
  int n_rst = 0, n_done = 0, n_busy = 0;
  int mode = 0;
  logic       man_v = 0;
  logic [3:0] man_g = 0;
  logic [3:0] ma, mb;
  logic       mv;

  always #5 clk = ~clk;

  gcd_sequencer dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_x(wr_x), .wr_y(wr_y),
    .count(count), .start(start),
    .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_gcd(rd_gcd),
    .rd_err(rd_err),
    .core_x(core_x), .core_y(core_y),
    .core_rst(core_rst),
    .core_valid(core_valid),
    .core_gcd(core_gcd)
  );

  always @(posedge clk) begin
    if (core_rst) begin
      ma <= core_x;
      mb <= core_y;
      mv <= 1'b0;
    end else if (!mv) begin
      if (ma == mb) mv <= 1'b1;
      else if (ma > mb) ma <= ma - mb;
      else mb <= mb - ma;
    end
  end

  assign core_valid = (mode == 0) ? mv :
                      (mode == 1) ? 1'b0 : man_v;
  assign core_gcd   = (mode == 0) ? ma : man_g;

  always @(posedge clk) begin
    if (!reset) begin
      if (core_rst) n_rst <= n_rst + 1;
      if (done) n_done <= n_done + 1;
      if (busy) n_busy <= n_busy + 1;
    end
  end

  task automatic chk(input string tag,
                     input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic wr(input [1:0] a,
                    input [3:0] x, input [3:0] y);
    @(negedge clk);
    wr_en = 1; wr_addr = a; wr_x = x; wr_y = y;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic rd(input string tag, input [1:0] a,
                    input [3:0] g, input e);
    rd_addr = a;
    #1;
    chk({tag, "_gcd"}, rd_gcd, g);
    chk({tag, "_err"}, rd_err, e);
  endtask

  task automatic wait_done(input int budget,
                           inout int cyc);
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done, 1);
    @(negedge clk);
  endtask

  task automatic run(input [2:0] c, input int budget,
                     output int cyc);
    @(negedge clk);
    count = c; start = 1;
    @(negedge clk);
    start = 0;
    cyc = 1;
    wait_done(budget, cyc);
  endtask

  int cyc, r0, d0, b0;

  initial begin
    reset = 1; wr_en = 0; wr_addr = 0;
    wr_x = 0; wr_y = 0; count = 0;
    start = 0; rd_addr = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_x", core_x, 0);
    rd("rst_slot0", 0, 0, 0);
    reset = 0;

    // single pair
    wr(0, 10, 2);
    r0 = n_rst; d0 = n_done;
    run(1, 200, cyc);
    chk("s1_rst_pulses", n_rst - r0, 1);
    chk("s1_done", n_done - d0, 1);
    rd("s1", 0, 2, 0);
    chk("s1_hold_x", core_x, 10);
    chk("s1_core_rst_idle", core_rst, 0);

    // four pairs
    wr(0, 12, 8); wr(1, 9, 6);
    wr(2, 7, 5);  wr(3, 15, 15);
    r0 = n_rst; d0 = n_done;
    run(4, 400, cyc);
    chk("s2_rst_pulses", n_rst - r0, 4);
    chk("s2_done", n_done - d0, 1);
    rd("s2_0", 0, 4, 0);
    rd("s2_1", 1, 3, 0);
    rd("s2_2", 2, 1, 0);
    rd("s2_3", 3, 15, 0);
    chk("s2_hold_y", core_y, 15);

    // timeout
    mode = 1;
    wr(0, 6, 4);
    run(1, 200, cyc);
    chk("s3_cycles", cyc, 67);
    rd("s3", 0, 0, 1);
    rd("s3_keep1", 1, 3, 0);
    mode = 0;

    // count zero
    r0 = n_rst; b0 = n_busy;
    run(0, 10, cyc);
    chk("s4_cycles", cyc, 1);
    chk("s4_busy", n_busy - b0, 0);
    chk("s4_core_rst", n_rst - r0, 0);

    // stale valid in the first WAIT cycle
    mode = 2; man_v = 1; man_g = 14;
    @(negedge clk);
    count = 1; start = 1;
    @(negedge clk);
    start = 0;
    chk("s5_launch", core_rst, 1);
    @(negedge clk);
    @(negedge clk);
    man_v = 0;
    chk("s5_still_busy", busy, 1);
    @(negedge clk);
    man_v = 1; man_g = 5;
    cyc = 0;
    wait_done(10, cyc);
    rd("s5", 0, 5, 0);
    man_v = 0;
    mode = 0;

    // count saturation: 7 behaves as 4
    r0 = n_rst;
    run(7, 400, cyc);
    chk("sat_rst_pulses", n_rst - r0, 4);
    rd("sat_0", 0, 2, 0);
    rd("sat_3", 3, 15, 0);

    // reset during WAIT of pair 2
    r0 = n_rst; d0 = n_done;
    @(negedge clk);
    count = 4; start = 1;
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (!((n_rst - r0) == 2 && busy && !core_rst)
           && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("s6_reached_wait2", cyc < 200, 1);
    reset = 1;
    #1;
    chk("s6_busy_in_rst", busy, 0);
    chk("s6_core_rst", core_rst, 1);
    chk("s6_core_x", core_x, 0);
    @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);
    chk("s6_no_done", n_done - d0, 0);
    chk("s6_busy_after", busy, 0);
    for (int i = 0; i < 4; i++)
      rd("s6_clear", 2'(i), 0, 0);

    // wr_en ignored while busy
    wr(0, 12, 8);
    @(negedge clk);
    count = 1; start = 1;
    @(negedge clk);
    start = 0;
    wr_en = 1; wr_addr = 0; wr_x = 9; wr_y = 6;
    @(negedge clk);
    wr_en = 0;
    cyc = 2;
    wait_done(200, cyc);
    run(1, 200, cyc);
    rd("s6_wr_busy", 0, 4, 0);
    chk("s6_wr_busy_x", core_x, 12);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_sequencer.md
GCD_SEQUENCER -- requirements
Module: gcd_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
  DEPTH  4   operand-pair slots (fixed, 2-bit addressing)
  TMO    63  WAIT-state cycle limit before timeout
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk         in   1  single clock, all logic on rising edge
  reset       in   1  synchronous, active-high reset
  wr_en       in   1  operand write strobe
  wr_addr     in   2  operand slot index
  wr_x        in   4  operand x for slot
  wr_y        in   4  operand y for slot
  count       in   3  number of pairs to run (0-4); sampled on accepted start
  start       in   1  run request, single-cycle pulse
  busy        out  1  run in progress
  done        out  1  one-cycle pulse at run end
  rd_addr     in   2  result slot index
  rd_gcd      out  4  result for rd_addr (combinational read)
  rd_err      out  1  timeout flag for rd_addr
  core_x      out  4  operand x driven to the GCD core
  core_y      out  4  operand y driven to the GCD core
  core_rst    out  1  restart strobe to the GCD core
  core_valid  in   1  core result valid (level; held until next core_rst)
  core_gcd    in   4  core result
REQ-003 Clock SHALL be named clk; reset SHALL be named reset and SHALL be synchronous and active-high.

Function
REQ-004 States SHALL be IDLE, LAUNCH, WAIT, STORE and DONE, with a 2-bit slot index idx and a 6-bit timer.
REQ-005 IDLE: when wr_en=1, the block SHALL write {wr_x, wr_y} to slot wr_addr; wr_en SHALL be ignored in every other state.
REQ-006 IDLE with start=1 and count=0 SHALL go to DONE with no core activity.
REQ-007 IDLE with start=1 and count in 1..4 SHALL latch count, set idx=0, and go to LAUNCH; count values 5-7 SHALL saturate to 4.
REQ-008 LAUNCH (exactly one cycle): core_rst=1; core_x/core_y = operands of slot idx; timer=0; next state WAIT.
REQ-009 WAIT: core_rst=0; the timer SHALL increment every cycle; core_valid SHALL be ignored in the first WAIT cycle (stale-valid guard).
REQ-010 WAIT exit on valid: from the second WAIT cycle onward, core_valid=1 SHALL latch core_gcd with err=0 and go to STORE.
REQ-011 WAIT exit on timeout: when the timer reaches TMO without a valid, the block SHALL latch gcd=0 with err=1 and go to STORE.
REQ-012 If core_valid and the timeout coincide in the same cycle, core_valid SHALL win (err=0).
REQ-013 STORE (one cycle): write the result and err to slot idx; if idx == count-1 go to DONE, else increment idx and go to LAUNCH.
REQ-014 DONE (one cycle): done=1; next state IDLE.
REQ-015 busy SHALL be 1 in LAUNCH, WAIT and STORE, and 0 in IDLE and DONE.
REQ-016 start SHALL be ignored outside IDLE.
REQ-017 core_x/core_y SHALL hold stable from LAUNCH through STORE, and SHALL hold the last launched values while idle.
REQ-018 Per-pair latency SHALL be 1 (LAUNCH) + N (WAIT cycles, N ≥ 2 on valid, N = TMO+1 on timeout) + 1 (STORE) cycles.
REQ-019 Results SHALL persist until reset or until overwritten by a later run; slots at or beyond count SHALL keep their previous contents.
REQ-020 Zero operands SHALL receive no special handling; a core hang on such operands SHALL be caught by the timeout.

Reset
REQ-021 While reset=1, the block SHALL force: state=IDLE, busy=0, done=0, core_rst=1, core_x=0, core_y=0, idx=0, timer=0, all operand, result and err slots cleared to 0.
REQ-022 Reset asserted mid-run (any state) SHALL abort the run on the next edge with no done pulse; the partial results SHALL be cleared.

Verification
REQ-023 The bench SHALL cover these directed scenarios with a behavioural GCD core model:
  1. Slot0=(10,2), count=1, start -> core_rst pulse, done, rd_gcd[0]=2, rd_err[0]=0.
  2. (12,8),(9,6),(7,5),(15,15), count=4 -> results 4,3,1,15; 4 core_rst pulses; one done.
  3. Core stub with core_valid stuck 0, count=1 -> done after 1+64+1+1 cycles; rd_gcd=0, rd_err=1.
  4. count=0, start -> done exactly one cycle after start; busy never 1; core_rst stays 0.
  5. Stale core_valid=1 held during the first WAIT cycle -> not captured; capture occurs on the later genuine valid.
  6. reset in WAIT of pair 2 -> busy=0, no done pulse, all results 0; wr_en pulsed while busy -> slot unchanged.
